pack_rr_arbiter: RTL

- Shares one 8-bit field packer between N_REQ requesters. Round-robin arbitration selects one requester per cycle.
- Each granted request's fields are packed as {A[3:0], B[1:0], ~C, D}, then pushed with the source index into an internal FIFO.
- The FIFO drains through a valid/ready output port.
- Sits between field-producing blocks and the downstream byte stream consumer.

---
 rtl/pack_rr_arbiter_if.sv | 29 ++
 rtl/pack_rr_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/pack_rr_arbiter_if.sv
// Handshake bundle between the requesters, the shared field packer and the byte consumer.
// The slave modport is the arbiter's view; the master modport drives requests and out_ready.
interface pack_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 4,
    parameter int IW    = 2
);
    logic [N_REQ-1:0]       req;
    logic [4*N_REQ-1:0]     a_in;
    logic [2*N_REQ-1:0]     b_in;
    logic [N_REQ-1:0]       c_in;
    logic [N_REQ-1:0]       d_in;
    logic [N_REQ-1:0]       gnt;
    logic [7:0]             out;
    logic [IW-1:0]          out_src;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output req, a_in, b_in, c_in, d_in, out_ready,
        input  gnt, out, out_src, out_valid, count
    );

    modport slave (
        input  req, a_in, b_in, c_in, d_in, out_ready,
        output gnt, out, out_src, out_valid, count
    );
endinterface

// File: rtl/pack_rr_arbiter.sv
// Round-robin arbiter feeding one 8-bit field packer; packed bytes are queued with their
// source index in a small FIFO that drains through a valid/ready port.
module pack_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 4,
    parameter int IW    = 2
) (
    input logic              clk,
    input logic              rst,
    pack_rr_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = IW + 1;
    localparam int EW = 8 + IW;

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count_r;
    logic [IW-1:0]      pri;
    logic [EW-1:0]      mem [DEPTH];

    logic               full;
    logic               push;
    logic               pop;
    logic               found;
    logic [IW-1:0]      gidx;
    logic [SW-1:0]      sum;
    logic [2*N_REQ-1:0] rot;
    logic [3:0]         a_sel;
    logic [1:0]         b_sel;
    logic               c_sel;
    logic               d_sel;

    function automatic logic [7:0] pack_fields(input logic [3:0] a, input logic [1:0] b,
                                               input logic c, input logic d);
        return {a, b, ~c, d};
    endfunction

    assign full = (count_r == CW'(DEPTH));
    assign pop  = (count_r != '0) && bus.out_ready;
    assign push = found && !full && !rst;

    // Rotate the doubled request vector so bit 0 is the current priority holder.
    always_comb begin
        rot   = {bus.req, bus.req} >> pri;
        found = 1'b0;
        gidx  = '0;
        sum   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, pri} + SW'(j);
                if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
                gidx  = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        bus.gnt = '0;
        a_sel   = '0;
        b_sel   = '0;
        c_sel   = 1'b0;
        d_sel   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx == IW'(i)) begin
                bus.gnt[i] = push;
                a_sel      = bus.a_in[4*i +: 4];
                b_sel      = bus.b_in[2*i +: 2];
                c_sel      = bus.c_in[i];
                d_sel      = bus.d_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            pri     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pri    <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is not reset; validity is tracked solely by count_r.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pack_fields(a_sel, b_sel, c_sel, d_sel), gidx};
    end

    assign {bus.out, bus.out_src} = mem[rd_ptr];
    assign bus.out_valid          = (count_r != '0);
    assign bus.count              = count_r;
endmodule
